// File: rtl/spi_master_ctrl_if.sv
// Request/response and SPI pin bundle for spi_master_ctrl.
// master: the controller's view; slave: the requester/pin-side view.
interface spi_master_ctrl_if;
    logic        cpol;
    logic        cpha;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        busy;
    logic        sck;
    logic        mosi;
    logic        miso;
    logic        csn;

    modport master (
        input  cpol, cpha, tx_data, tx_valid, miso,
        output tx_ready, rx_data, rx_valid, busy, sck, mosi, csn
    );

    modport slave (
        output cpol, cpha, tx_data, tx_valid, miso,
        input  tx_ready, rx_data, rx_valid, busy, sck, mosi, csn
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master, one MSB-first DATA_WIDTH frame per request in any CPOL/CPHA mode; rx_valid 1+(2N+1)*CLK_DIV cycles after accept.
// tx_ready only in IDLE; requests seen while busy are dropped, not queued.
module spi_master_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic              clk,
    input  logic              rstn,
    spi_master_ctrl_if.master bus
);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t                state;
    logic [DIV_W-1:0]      div_cnt;
    logic [EDGE_W-1:0]     edge_cnt;
    logic [DATA_WIDTH-1:0] tx_sh;
    logic [DATA_WIDTH-1:0] rx_sh;
    logic                  cpol_l;
    logic                  cpha_l;

    logic                  tick;
    logic [EDGE_W-1:0]     edge_nxt;
    logic                  leading;
    logic                  do_sample;
    logic                  do_drive;

    assign tick      = (div_cnt == DIV_LAST);
    assign edge_nxt  = edge_cnt + EDGE_W'(1);
    assign leading   = edge_nxt[0];
    // Sample on leading edges when cpha=0, trailing edges when cpha=1; drive on the others.
    assign do_sample = leading ^ cpha_l;
    assign do_drive  = !do_sample && (edge_nxt != EDGE_LAST);

    assign bus.tx_ready = (state == IDLE);
    assign bus.busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            div_cnt      <= '0;
            edge_cnt     <= '0;
            tx_sh        <= '0;
            rx_sh        <= '0;
            cpol_l       <= 1'b0;
            cpha_l       <= 1'b0;
            bus.csn      <= 1'b1;
            bus.sck      <= bus.cpol;
            bus.mosi     <= 1'b0;
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
        end else begin
            bus.rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    bus.sck <= bus.cpol;
                    if (bus.tx_valid) begin
                        cpol_l   <= bus.cpol;
                        cpha_l   <= bus.cpha;
                        div_cnt  <= '0;
                        edge_cnt <= '0;
                        rx_sh    <= '0;
                        bus.csn  <= 1'b0;
                        state    <= SETUP;
                        if (!bus.cpha) begin
                            bus.mosi <= bus.tx_data[DATA_WIDTH-1];
                            tx_sh    <= bus.tx_data[DATA_WIDTH-1:0] << 1;
                        end else begin
                            tx_sh    <= bus.tx_data[DATA_WIDTH-1:0];
                        end
                    end
                end
                SETUP, SHIFT: begin
                    if (tick) begin
                        div_cnt  <= '0;
                        edge_cnt <= edge_nxt;
                        bus.sck  <= leading ? ~cpol_l : cpol_l;
                        if (do_sample) begin
                            rx_sh <= (rx_sh << 1) | DATA_WIDTH'(bus.miso);
                        end
                        if (do_drive) begin
                            bus.mosi <= tx_sh[DATA_WIDTH-1];
                            tx_sh    <= tx_sh << 1;
                        end
                        state <= (edge_nxt == EDGE_LAST) ? HOLD : SHIFT;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                HOLD: begin
                    if (tick) begin
                        div_cnt      <= '0;
                        bus.csn      <= 1'b1;
                        bus.sck      <= cpol_l;
                        bus.rx_valid <= 1'b1;
                        bus.rx_data  <= 32'(rx_sh);
                        state        <= GAP;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                GAP: begin
                    if (tick) begin
                        div_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Drives an 8-bit/CLK_DIV=4 and a 32-bit/CLK_DIV=1 controller against a behavioural SPI slave.
module tb_spi_master_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]  rstn_d, cpol_d, cpha_d, txv_d, smiso;
    logic [31:0] txd_d [2];
    logic        loop32;

    logic [1:0]  sck_v, csn_v, mosi_v, rxv_v, rdy_v, busy_v;
    logic [31:0] rxd_v [2];

    spi_master_ctrl_if b8 ();
    spi_master_ctrl_if b32 ();

    spi_master_ctrl #(.DATA_WIDTH(8), .CLK_DIV(4)) dut8 (
        .clk (clk), .rstn(rstn_d[0]), .bus(b8)
    );
    spi_master_ctrl #(.DATA_WIDTH(32), .CLK_DIV(1)) dut32 (
        .clk (clk), .rstn(rstn_d[1]), .bus(b32)
    );

    assign b8.cpol = cpol_d[0];      assign b32.cpol = cpol_d[1];
    assign b8.cpha = cpha_d[0];      assign b32.cpha = cpha_d[1];
    assign b8.tx_data = txd_d[0];    assign b32.tx_data = txd_d[1];
    assign b8.tx_valid = txv_d[0];   assign b32.tx_valid = txv_d[1];
    assign b8.miso = smiso[0];
    assign b32.miso = loop32 ? b32.mosi : smiso[1];
    assign sck_v  = {b32.sck, b8.sck};
    assign csn_v  = {b32.csn, b8.csn};
    assign mosi_v = {b32.mosi, b8.mosi};
    assign rxv_v  = {b32.rx_valid, b8.rx_valid};
    assign rdy_v  = {b32.tx_ready, b8.tx_ready};
    assign busy_v = {b32.busy, b8.busy};
    assign rxd_v[0] = b8.rx_data;
    assign rxd_v[1] = b32.rx_data;

    int total = 0;
    int bad = 0;

    function automatic int wd(input int i);
        return (i == 0) ? 8 : 32;
    endfunction
    function automatic int dv(input int i);
        return (i == 0) ? 4 : 1;
    endfunction
    function automatic logic [31:0] mask(input int i);
        return (i == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    endfunction

    // Slave model and monitor state, one slot per controller.
    int          rxv_cnt [2], rxv_cyc [2], edges [2], fr_cnt [2], fr_edges [2];
    int          gapcnt [2], gap_last [2], csn_falls [2], csn_fall_cyc [2];
    logic [31:0] sh [2], srx [2], fr_rx [2], fr_prev [2], pre [2];
    logic        act [2], mbad [2], fr_mbad [2], st_ok [2], end_ok [2];
    logic        psck [2], pmosi [2], s_cpol [2], s_cpha [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            rxv_cnt[i] = 0; rxv_cyc[i] = 0; edges[i] = 0; fr_cnt[i] = 0; fr_edges[i] = 0;
            gapcnt[i] = 0; gap_last[i] = 0; csn_falls[i] = 0; csn_fall_cyc[i] = 0;
            sh[i] = 0; srx[i] = 0; fr_rx[i] = 0; fr_prev[i] = 0; pre[i] = 0;
            act[i] = 0; mbad[i] = 0; fr_mbad[i] = 0; st_ok[i] = 0; end_ok[i] = 0;
            psck[i] = 0; pmosi[i] = 0; s_cpol[i] = 0; s_cpha[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                logic ld;
                if (rxv_v[i] === 1'b1) begin
                    rxv_cnt[i]++;
                    rxv_cyc[i] = cyc;
                end
                if (csn_v[i] === 1'b0) begin
                    if (!act[i]) begin
                        act[i] = 1'b1; edges[i] = 0; mbad[i] = 1'b0; srx[i] = 0;
                        sh[i] = pre[i];
                        st_ok[i] = (sck_v[i] == s_cpol[i]);
                        gap_last[i] = gapcnt[i];
                        csn_falls[i]++;
                        csn_fall_cyc[i] = cyc;
                        if (!s_cpha[i]) begin
                            smiso[i] = sh[i][wd(i)-1];
                            sh[i] = sh[i] << 1;
                        end
                    end else if (sck_v[i] != psck[i]) begin
                        edges[i]++;
                        ld = (sck_v[i] != s_cpol[i]);
                        if (ld != s_cpha[i]) begin
                            srx[i] = {srx[i][30:0], mosi_v[i]};
                            if (mosi_v[i] != pmosi[i]) mbad[i] = 1'b1;
                        end else begin
                            smiso[i] = sh[i][wd(i)-1];
                            sh[i] = sh[i] << 1;
                        end
                    end
                end else if (act[i]) begin
                    act[i] = 1'b0;
                    fr_cnt[i]++;
                    fr_prev[i] = fr_rx[i];
                    fr_rx[i] = srx[i] & mask(i);
                    fr_edges[i] = edges[i];
                    fr_mbad[i] = mbad[i];
                    end_ok[i] = (sck_v[i] == s_cpol[i]);
                    gapcnt[i] = 0;
                end
                if (csn_v[i] === 1'b1 && busy_v[i] === 1'b1) gapcnt[i]++;
                psck[i] = sck_v[i];
                pmosi[i] = mosi_v[i];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] actual, input logic [31:0] req);
        total++;
        if (actual !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, actual, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input int i, output bit ok);
        int k = 0;
        while (rdy_v[i] !== 1'b1 && k < 400) begin tick(); k++; end
        ok = (rdy_v[i] === 1'b1);
        if (!ok) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_frame(input int i, input logic cp, input logic ch, input logic [31:0] tx,
                             input logic [31:0] pr, input logic [31:0] exp_rx, input bit junk);
        int t0, n0, f0, k, lim, n, d;
        bit ok;
        n = wd(i); d = dv(i);
        lim = (2 * n + 2) * d + 20;
        cpol_d[i] = cp; cpha_d[i] = ch; s_cpol[i] = cp; s_cpha[i] = ch; pre[i] = pr;
        tick();
        wait_ready(i, ok);
        if (!ok) return;
        n0 = rxv_cnt[i]; f0 = fr_cnt[i]; t0 = cyc;
        txd_d[i] = tx; txv_d[i] = 1'b1;
        tick();
        txv_d[i] = 1'b0;
        if (junk) begin
            repeat (3) tick();
            txv_d[i] = 1'b1; txd_d[i] = ~tx; cpol_d[i] = ~cp; cpha_d[i] = ~ch;
            tick();
            txv_d[i] = 1'b0;
        end
        k = 0;
        while (rxv_cnt[i] == n0 && k < lim) begin tick(); k++; end
        if (rxv_cnt[i] == n0) begin chk("rx_valid_timeout", 32'd0, 32'd1); return; end
        chk("rx_latency", rxv_cyc[i] - t0, 1 + (2 * n + 1) * d);
        chk("rx_data", rxd_v[i], exp_rx);
        chk("slave_frames", fr_cnt[i] - f0, 1);
        chk("slave_rx", fr_rx[i], tx & mask(i));
        chk("sck_toggles", fr_edges[i], 2 * n);
        chk("mosi_stable", {31'd0, fr_mbad[i]}, 0);
        chk("sck_idle_start", {31'd0, st_ok[i]}, 1);
        chk("sck_idle_end", {31'd0, end_ok[i]}, 1);
        k = 0;
        while (rdy_v[i] !== 1'b1 && k < lim) begin tick(); k++; end
        chk("ready_latency", cyc - t0, 1 + (2 * n + 2) * d);
        repeat (5) tick();
        chk("rx_pulses", rxv_cnt[i] - n0, 1);
    endtask

    typedef struct {
        logic        cpol;
        logic        cpha;
        logic [31:0] tx;
        logic [31:0] pre;
        logic [31:0] exp_rx;
        logic [31:0] exp_slave;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n0, k, t0;
        bit ok;
        logic [31:0] a, b;

        vecs[0] = '{1'b0, 1'b0, 32'hA5, 32'h3C, 32'h3C, 32'hA5};
        vecs[1] = '{1'b1, 1'b1, 32'h5A, 32'hC3, 32'hC3, 32'h5A};
        vecs[2] = '{1'b0, 1'b1, 32'h81, 32'h7E, 32'h7E, 32'h81};
        vecs[3] = '{1'b1, 1'b0, 32'h81, 32'h18, 32'h18, 32'h81};
        vecs[4] = '{1'b0, 1'b0, 32'hFF, 32'h00, 32'h00, 32'hFF};
        vecs[5] = '{1'b1, 1'b1, 32'h00, 32'hFF, 32'hFF, 32'h00};

        rstn_d = 2'b00; cpol_d = 2'b01; cpha_d = 2'b00; txv_d = 2'b00; smiso = 2'b00;
        txd_d[0] = 0; txd_d[1] = 0; loop32 = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            chk("reset_csn", {31'd0, csn_v[i]}, 1);
            chk("reset_sck", {31'd0, sck_v[i]}, {31'd0, cpol_d[i]});
            chk("reset_mosi", {31'd0, mosi_v[i]}, 0);
            chk("reset_rx_data", rxd_v[i], 0);
            chk("reset_rx_valid", {31'd0, rxv_v[i]}, 0);
            chk("reset_tx_ready", {31'd0, rdy_v[i]}, 1);
            chk("reset_busy", {31'd0, busy_v[i]}, 0);
        end
        cpol_d = 2'b10;
        tick();
        chk("reset_sck_follows_cpol8", {31'd0, sck_v[0]}, 0);
        chk("reset_sck_follows_cpol32", {31'd0, sck_v[1]}, 1);
        rstn_d = 2'b11;
        tick();

        for (int v = 0; v < 6; v++) begin
            run_frame(0, vecs[v].cpol, vecs[v].cpha, vecs[v].tx, vecs[v].pre, vecs[v].exp_rx, 1'b0);
            chk("table_slave_rx", fr_rx[0], vecs[v].exp_slave);
        end

        // Back-to-back with tx_valid held high.
        cpol_d[0] = 0; cpha_d[0] = 0; s_cpol[0] = 0; s_cpha[0] = 0; pre[0] = 32'h96;
        tick();
        wait_ready(0, ok);
        if (ok) begin
            n0 = rxv_cnt[0]; k = csn_falls[0]; t0 = cyc;
            txd_d[0] = 32'h11; txv_d[0] = 1'b1;
            tick();
            txd_d[0] = 32'h22;
            while (csn_falls[0] < k + 2 && cyc - t0 < 200) tick();
            txv_d[0] = 1'b0;
            chk("b2b_second_accept", csn_fall_cyc[0] - 1 - t0, 1 + (2 * 8 + 2) * 4);
            chk("b2b_csn_gap", gap_last[0], 4);
            while (rxv_cnt[0] < n0 + 2 && cyc - t0 < 300) tick();
            chk("b2b_rx_pulses", rxv_cnt[0] - n0, 2);
            chk("b2b_rx_data", rxd_v[0], 32'h96);
            chk("b2b_slave_first", fr_prev[0], 32'h11);
            chk("b2b_slave_second", fr_rx[0], 32'h22);
        end

        // Reset in the middle of a frame.
        cpol_d[0] = 1; cpha_d[0] = 0; s_cpol[0] = 1; s_cpha[0] = 0; pre[0] = 32'h3C;
        tick();
        wait_ready(0, ok);
        if (ok) begin
            n0 = rxv_cnt[0];
            txd_d[0] = 32'hA5; txv_d[0] = 1'b1;
            tick();
            txv_d[0] = 1'b0;
            k = 0;
            while (!(act[0] && edges[0] >= 7) && k < 200) begin tick(); k++; end
            chk("abort_reached_bit4", {31'd0, act[0]}, 1);
            rstn_d[0] = 1'b0;
            tick();
            chk("abort_csn", {31'd0, csn_v[0]}, 1);
            chk("abort_sck", {31'd0, sck_v[0]}, 1);
            rstn_d[0] = 1'b1;
            repeat (80) tick();
            chk("abort_no_rx_valid", rxv_cnt[0] - n0, 0);
            chk("abort_idle_ready", {31'd0, rdy_v[0]}, 1);
            run_frame(0, 1'b1, 1'b0, 32'hF0, 32'h5A, 32'h5A, 1'b0);
        end

        // 32-bit loopback, cpha=1.
        loop32 = 1'b1;
        run_frame(1, 1'b0, 1'b1, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 1'b0);
        run_frame(1, 1'b1, 1'b1, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0);
        loop32 = 1'b0;

        for (int r = 0; r < 16; r++) begin
            int i;
            i = r % 2;
            a = $urandom & mask(i);
            b = $urandom & mask(i);
            run_frame(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, b, b,
                      bit'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
